alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
// - Multi-cycle 16-bit unsigned multiply/divide sequencer that drives the 16-bit ripple ALU as its datapath.
// - It generates A, B, BNegate and ALUOp, then consumes Result and CarryOut once per iteration.
// - Sits beside the ALU in the execute stage; the ALU itself is instantiated outside this block.
// - Uses one shared ALU add/subtract per cycle: shift-add multiply, restoring divide.
// PARAMETERS
// - ALU_OP_ADD  3'b010  ALUOp code selecting the adder; BNegate=1 turns it into subtract (A + ~B + 1)
// - ITER        16      iteration count; equals the operand width and is fixed at 16
// PORTS
// - clk           in   1   single clock; all state updates on rising edge
// - reset         in   1   synchronous, active-high reset
// - in_valid      in   1   operation request
// - in_ready      out  1   block is idle and can accept a request
// - in_op         in   1   0 = multiply, 1 = divide
// - in_a          in   16  multiplicand / dividend
// - in_b          in   16  multiplier / divisor
// - out_valid     out  1   result available
// - out_ready     in   1   consumer accepts the result
// - out_hi        out  16  multiply: product[31:16]; divide: remainder
// - out_lo        out  16  multiply: product[15:0]; divide: quotient
// - out_divzero   out  1   divide with in_b == 0
// - alu_a         out  16  ALU operand A
// - alu_b         out  16  ALU operand B
// - alu_bnegate   out  1   ALU BNegate (0 = add, 1 = subtract)
// - alu_op        out  3   ALU ALUOp; always ALU_OP_ADD
// - alu_result    in   16  ALU Result
// - alu_carryout  in   1   ALU CarryOut (for subtract, 1 = no borrow)
// BEHAVIOUR
// - States: IDLE -> RUN -> DONE -> IDLE.
// - Reset: state = IDLE, in_ready = 1, out_valid = 0, out_hi/out_lo = 0, out_divzero = 0, counter = 0.
// - Reset takes effect immediately in any state; a run in progress is aborted and its result is discarded.
// - Accept: a request is taken when in_valid && in_ready. Operands are latched and the block enters RUN with counter = 0.
// - in_ready = (state == IDLE). It is not asserted in the same cycle that DONE is left.
// - Multiply:
//   - Registers: acc = 0, mq = in_a, mcand = in_b.
//   - ALU drive: alu_a = acc, alu_b = mcand, alu_bnegate = 0.
//   - Each cycle, if mq[0]: {c, acc} = {alu_carryout, alu_result}; otherwise {c, acc} = {0, acc}.
//   - Then {acc, mq} = {c, acc, mq} >> 1.
//   - After 16 cycles: out_hi = acc, out_lo = mq.
// - Divide:
//   - Registers: R = 0 (17 bits), Q = in_a, D = in_b.
//   - Each cycle, shift {R, Q} left by 1.
//   - ALU drive: alu_a = R[15:0], alu_b = D, alu_bnegate = 1.
//   - If R[16] | alu_carryout: R = {0, alu_result} and Q[0] = 1; otherwise R is kept and Q[0] = 0.
//   - After 16 cycles: out_hi = R[15:0], out_lo = Q.
// - Divide by zero: if in_op = 1 and in_b == 0, RUN is skipped and the block goes straight to DONE.
//   - Outputs: out_lo = 16'hFFFF, out_hi = in_a, out_divzero = 1.
// - Latency: out_valid rises 17 cycles after the accept edge for a normal run, and 1 cycle after it for a bypass.
// - DONE:
//   - out_valid = 1; outputs stay stable until out_ready.
//   - On out_valid && out_ready, the next state is IDLE and out_valid = 0.
//   - out_divzero is cleared on the next accept.
// - alu_op is held at ALU_OP_ADD.
// - alu_a, alu_b and alu_bnegate are don't-care outside RUN and are driven to 0 there.
// - The ALU Zero and Overflow outputs are not consumed.
// CONFIGURATION
// - MULDIV_ZERO_BYPASS_EN defined: a multiply with in_a == 0 or in_b == 0 skips RUN.
//   - The block goes to DONE the next cycle with out_hi = out_lo = 0 and out_divzero = 0.
// - MULDIV_ZERO_BYPASS_EN undefined: every multiply takes the full 16 iterations.
//   - The result values are identical; only the latency differs.
// TESTING
// - mul 16'h0003 x 16'h0005 -> out_hi = 16'h0000, out_lo = 16'h000F, out_valid 17 cycles after accept.
// - mul 16'hFFFF x 16'hFFFF -> out_hi = 16'hFFFE, out_lo = 16'h0001 (checks carry into acc).
// - div 16'd100 / 16'd7 -> out_lo = 16'd14, out_hi = 16'd2, out_divzero = 0.
// - div 16'hFFFF / 16'h8001 -> out_lo = 1, out_hi = 16'h7FFE.
// - div 16'h1234 / 0 -> out_lo = 16'hFFFF, out_hi = 16'h1234, out_divzero = 1, 1-cycle latency.
// - Assert reset at cycle 8 of a multiply -> next cycle in_ready = 1 and out_valid = 0.
// - Hold out_ready = 0 for 5 cycles -> outputs stable, in_ready = 0.
// - With MULDIV_ZERO_BYPASS_EN: mul 0 x 16'h1234 -> result 0 with 1-cycle latency.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 16-bit unsigned multiply/divide sequencer driving an external ripple ALU.
// Optional MULDIV_ZERO_BYPASS_EN: multiplies with a zero operand skip the iterations.
module alu_muldiv_seq #(
  parameter logic [2:0] ALU_OP_ADD = 3'b010,
  parameter int         ITER       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_hi,
  output logic [15:0] out_lo,
  output logic        out_divzero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_bnegate,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_carryout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST = 5'(ITER);

  state_t      state, state_next;
  logic        op_r;
  logic        bypass_r;
  logic [4:0]  count;
  logic [15:0] hi_r;
  logic [15:0] lo_r;
  logic [15:0] b_r;

  logic        accept;
  logic        iterate;
  logic        finish;
  logic        div_zero_req;
  logic        skip_req;
  logic [16:0] mul_sum;
  logic [16:0] div_sh;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign alu_op    = ALU_OP_ADD;

  assign accept  = in_valid && in_ready;
  assign iterate = (state == RUN) && !bypass_r && (count < LAST);
  assign finish  = (state == RUN) && (bypass_r || (count == LAST));

  assign div_zero_req = in_op && (in_b == 16'd0);

  always_comb begin
    skip_req = div_zero_req;
`ifdef MULDIV_ZERO_BYPASS_EN
    if (!in_op && ((in_a == 16'd0) || (in_b == 16'd0)))
      skip_req = 1'b1;
`endif
  end

  // The remainder is stored as 16 bits: after a restore it is below the divisor,
  // so its 17th bit only exists transiently in the shifted value.
  assign div_sh  = {hi_r, lo_r[15]};
  assign mul_sum = lo_r[0] ? {alu_carryout, alu_result} : {1'b0, hi_r};

  always_comb begin
    alu_a       = 16'd0;
    alu_b       = 16'd0;
    alu_bnegate = 1'b0;
    if (iterate) begin
      alu_a       = op_r ? div_sh[15:0] : hi_r;
      alu_b       = b_r;
      alu_bnegate = op_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (finish)    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Bypassed requests preload their final answer so the finish step just copies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r        <= 1'b0;
      bypass_r    <= 1'b0;
      count       <= 5'd0;
      hi_r        <= 16'd0;
      lo_r        <= 16'd0;
      b_r         <= 16'd0;
      out_hi      <= 16'd0;
      out_lo      <= 16'd0;
      out_divzero <= 1'b0;
    end else if (accept) begin
      op_r        <= in_op;
      bypass_r    <= skip_req;
      count       <= 5'd0;
      b_r         <= in_b;
      out_divzero <= div_zero_req;
      if (div_zero_req) begin
        hi_r <= in_a;
        lo_r <= 16'hFFFF;
      end else begin
        hi_r <= 16'd0;
        lo_r <= skip_req ? 16'd0 : in_a;
      end
    end else if (iterate) begin
      count <= count + 5'd1;
      if (!op_r) begin
        hi_r <= mul_sum[16:1];
        lo_r <= {mul_sum[0], lo_r[15:1]};
      end else if (div_sh[16] || alu_carryout) begin
        hi_r <= alu_result;
        lo_r <= {lo_r[14:0], 1'b1};
      end else begin
        hi_r <= div_sh[15:0];
        lo_r <= {lo_r[14:0], 1'b0};
      end
    end else if (finish) begin
      out_hi <= hi_r;
      out_lo <= lo_r;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: behavioural ALU plus arithmetic reference model.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_hi;
  logic [15:0] out_lo;
  logic        out_divzero;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_bnegate;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_carryout;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hi       (out_hi),
    .out_lo       (out_lo),
    .out_divzero  (out_divzero),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_bnegate  (alu_bnegate),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout)
  );

  // Ripple ALU stand-in: add, or A + ~B + 1 when BNegate is set
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, (alu_bnegate ? ~alu_b : alu_b)} + {16'd0, alu_bnegate};
    alu_result   = alu_sum[15:0];
    alu_carryout = alu_sum[16];
  end

  function automatic int exp_latency(input logic op, input logic [15:0] a, input logic [15:0] b);
    if (op && b == 16'd0) return 1;
`ifdef MULDIV_ZERO_BYPASS_EN
    if (!op && (a == 16'd0 || b == 16'd0)) return 1;
`endif
    if (a == 16'hFFFF && b == 16'hFFFF && op) return 17;
    return 17;
  endfunction

  task automatic model(input logic op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] hi, output logic [15:0] lo, output logic dz);
    logic [31:0] prod;
    if (!op) begin
      prod = {16'd0, a} * {16'd0, b};
      hi = prod[31:16];
      lo = prod[15:0];
      dz = 1'b0;
    end else if (b == 16'd0) begin
      hi = a;
      lo = 16'hFFFF;
      dz = 1'b1;
    end else begin
      hi = a % b;
      lo = a / b;
      dz = 1'b0;
    end
  endtask

  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] hi, output logic [15:0] lo, output logic dz,
                        output int lat, output logic ok, output logic proto_bad, output logic alu_bad);
    int w;
    ok = 1'b1; proto_bad = 1'b0; alu_bad = 1'b0; lat = 0;
    hi = 16'd0; lo = 16'd0; dz = 1'b0;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      if (alu_op !== 3'b010) alu_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      ok = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    hi = out_hi; lo = out_lo; dz = out_divzero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_hi !== hi || out_lo !== lo || out_divzero !== dz || out_valid !== 1'b1 || in_ready !== 1'b0)
        proto_bad = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) proto_bad = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    tests_run++;
    if (out_hi !== 16'd0 || out_lo !== 16'd0 || out_divzero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: hi=%h lo=%h dz=%b, expected 0000 0000 0", out_hi, out_lo, out_divzero);
    end
    tests_run++;
    if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_bnegate !== 1'b0 || alu_op !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL reset_alu: a=%h b=%h bneg=%b op=%b, expected 0000 0000 0 010",
               alu_a, alu_b, alu_bnegate, alu_op);
    end
    reset = 1'b0;
  endtask

  task automatic check_op(input string name, input logic op, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
    logic [15:0] hi, lo, ehi, elo;
    logic dz, edz, ok, pbad, abad;
    int lat, elat;
    model(op, a, b, ehi, elo, edz);
    elat = exp_latency(op, a, b);
    run_op(op, a, b, hold, hi, lo, dz, lat, ok, pbad, abad);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL %s timeout: op=%b a=%h b=%h got no result, expected one", name, op, a, b);
      return;
    end
    tests_run++;
    if (hi !== ehi || lo !== elo || dz !== edz) begin
      tests_failed++;
      $display("[TB] FAIL %s result: op=%b a=%h b=%h got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
               name, op, a, b, hi, lo, dz, ehi, elo, edz);
    end
    tests_run++;
    if (lat != elat) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: op=%b a=%h b=%h got %0d, expected %0d", name, op, a, b, lat, elat);
    end
    tests_run++;
    if (pbad || abad) begin
      tests_failed++;
      $display("[TB] FAIL %s protocol: handshake_bad=%b alu_op_bad=%b, expected 0 0", name, pbad, abad);
    end
  endtask

  task automatic test_directed;
    logic        ops [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] as  [5] = '{16'h0003, 16'hFFFF, 16'd100, 16'hFFFF, 16'h1234};
    logic [15:0] bs  [5] = '{16'h0005, 16'hFFFF, 16'd7,   16'h8001, 16'h0000};
    logic [15:0] his [5] = '{16'h0000, 16'hFFFE, 16'd2,   16'h7FFE, 16'h1234};
    logic [15:0] los [5] = '{16'h000F, 16'h0001, 16'd14,  16'h0001, 16'hFFFF};
    logic [15:0] ehi, elo;
    logic edz;
    for (int i = 0; i < 5; i++) begin
      model(ops[i], as[i], bs[i], ehi, elo, edz);
      tests_run++;
      if (ehi !== his[i] || elo !== los[i]) begin
        tests_failed++;
        $display("[TB] FAIL directed_model %0d: model hi=%h lo=%h, expected %h %h", i, ehi, elo, his[i], los[i]);
      end
      check_op("directed", ops[i], as[i], bs[i], 0);
    end
  endtask

  task automatic test_random;
    logic op;
    logic [15:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(1, 15));
        1:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: b = 16'($urandom_range(1, 16'hFFFF));
      endcase
      check_op("random", op, a, b, 0);
    end
  endtask

  task automatic test_back_to_back;
    check_op("b2b_div0", 1'b1, 16'hBEEF, 16'h0000, 0);
    check_op("b2b_div", 1'b1, 16'h00FF, 16'h0010, 0);
    check_op("b2b_mul", 1'b0, 16'h8000, 16'h0002, 0);
  endtask

  task automatic test_backpressure;
    check_op("backpressure_mul", 1'b0, 16'h1234, 16'h5678, 5);
    check_op("backpressure_div0", 1'b1, 16'h4321, 16'h0000, 5);
  endtask

  task automatic test_zero_mul;
    check_op("zero_mul_a", 1'b0, 16'h0000, 16'h1234, 0);
    check_op("zero_mul_b", 1'b0, 16'h1234, 16'h0000, 0);
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    tests_run++;
    if (out_hi !== 16'd0 || out_lo !== 16'd0 || out_divzero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_outputs: hi=%h lo=%h dz=%b, expected 0000 0000 0", out_hi, out_lo, out_divzero);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrun_discard: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_zero_mul();
    test_random();
    test_reset_mid_run();
    check_op("after_reset", 1'b1, 16'd1000, 16'd33, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
